// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader
// Purpose  : Drains a sync_fifo read port into a framed valid/ready stream,
//            hiding the FIFO read latency behind a 2-entry output buffer.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [15:0]           pkt_count
);

  localparam logic [15:0] c_last_idx = 16'(PKT_LEN - 1);

  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [15:0]           r_word_idx;
  logic [15:0]           r_pkt_count;

  logic                  w_pop;
  logic [1:0]            w_remain;
  logic [2:0]            w_pending;

  assign w_pop     = out_valid && out_ready;
  // Words left in the buffer after this edge's pop, before any capture.
  assign w_remain  = r_occ - {1'b0, w_pop};
  assign w_pending = {1'b0, w_remain} + {2'b00, r_inflight};

  // Gated by rstn so no read can be issued while the block is held in reset.
  assign fifo_rd_en = rstn && !fifo_empty && (w_pending < 3'd2);

  assign out_valid = (r_occ != 2'd0);
  assign out_data  = r_head;
  assign out_last  = out_valid && (r_word_idx == c_last_idx);
  assign pkt_count = r_pkt_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_occ      <= w_pending[1:0];
      r_inflight <= fifo_rd_en;
      if (w_pop && (r_occ == 2'd2)) begin
        r_head <= r_tail;
      end
      // The arriving word lands behind whatever survives the pop.
      if (r_inflight) begin
        if (w_remain == 2'd0) begin
          r_head <= fifo_dout;
        end else begin
          r_tail <= fifo_dout;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_word_idx  <= 16'd0;
      r_pkt_count <= 16'd0;
    end else if (w_pop) begin
      if (r_word_idx == c_last_idx) begin
        r_word_idx  <= 16'd0;
        r_pkt_count <= r_pkt_count + 16'd1;
      end else begin
        r_word_idx  <= r_word_idx + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side master for `sync_fifo`: drains the FIFO through its `rd_en`/`dout`/`empty` port and presents the words as a valid/ready stream with packet framing. It sits directly behind a `sync_fifo` instance and feeds downstream consumers that apply backpressure. The block hides the FIFO's one-cycle read latency with a 2-entry output buffer, so it sustains one word per cycle when the sink is always ready.

## Interface
- `DATA_WIDTH`, 8: word width; must match the attached `sync_fifo`.
- `PKT_LEN`, 4: words per packet; `out_last` marks every PKT_LEN-th word; legal range 1..65535.

- `clk`, input, 1: single clock; all logic on the rising edge.
- `rstn`, input, 1: reset, asynchronous and active-low; shared with the attached `sync_fifo`.
- `fifo_empty`, input, 1: FIFO `empty`.
- `fifo_dout`, input, DATA_WIDTH: FIFO `dout`; valid in the cycle after an accepted read edge.
- `fifo_rd_en`, output, 1: FIFO `rd_en`.
- `out_valid`, output, 1: the stream word is valid.
- `out_ready`, input, 1: the sink accepts the word.
- `out_data`, output, DATA_WIDTH: the stream word.
- `out_last`, output, 1: final word of a packet; qualified by `out_valid`.
- `pkt_count`, output, 16: completed packets, wrapping at 2^16.

## Operation
- **FIFO read contract**
  - A read is issued when `fifo_rd_en`=1 at a rising edge while `fifo_empty`=0.
  - The popped word appears on `fifo_dout` in the following cycle.
  - The block never asserts `fifo_rd_en` while `fifo_empty`=1.
- **Internal state**
  - `occ`: buffer occupancy, 0..2.
  - `inflight`: 1 bit; a read was issued last edge and its data is arriving this cycle.
  - `pop`: `out_valid && out_ready`.
- **Read issue rule:** `fifo_rd_en = !fifo_empty && (occ + inflight - pop) < 2`.
  - This is combinational from `out_ready`; the path is accepted.
- **Capture:** when `inflight`=1, `fifo_dout` is written into the buffer at the edge, behind any remaining word.
- **Occupancy update per edge:** `occ_next = occ + inflight - pop`. Overflow past 2 is impossible by construction. The bench asserts it never happens.
- **Output**
  - `out_valid = (occ != 0)`; `out_data` is the head entry.
  - Both hold stable while `out_valid && !out_ready`.
  - Order is strictly FIFO order.
- **Framing**
  - `word_idx`, 0..PKT_LEN-1, increments on each `pop` and wraps to 0 after PKT_LEN-1.
  - `out_last = out_valid && (word_idx == PKT_LEN-1)`.
  - `pkt_count` increments on every `pop` with `out_last`=1.
  - PKT_LEN=1 means every word is last.
- **Simultaneous capture and pop:** the head leaves, the new word enters, and `occ` is unchanged.

## Timing
- **Reset values** (async assert, applied immediately):
  - `fifo_rd_en`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `pkt_count`=0.
  - Internal state cleared: `occ`=0, `inflight`=0, `word_idx`=0.
  - Deassertion takes effect at the first rising edge with `rstn`=1.
- **Latency:** `fifo_empty` falls in cycle N with the buffer empty:
  - `fifo_rd_en`=1 in cycle N;
  - data on `fifo_dout` in cycle N+1;
  - `out_valid`=1 in cycle N+2.
- **Throughput:** with `out_ready` held high and the FIFO non-empty, one word per cycle after the initial 2-cycle latency.
- **Backpressure:** with `out_ready`=0, at most 2 further words are read, then `fifo_rd_en` stays 0.
  - Each cycle `out_ready` is high afterwards frees exactly one slot.
- **FIFO empties mid-stream:** the in-flight word is still captured. `out_valid` drops once the buffer drains. No bubble word is emitted.
- **Reset mid-operation:** buffered and in-flight words are discarded. The attached FIFO is reset by the same `rstn`. Framing restarts at word 0.

## Test plan
- **Reset:** assert `rstn`=0 for 2 cycles → all outputs 0, including `pkt_count`; `fifo_rd_en`=0 while `fifo_empty`=1.
- **Streaming:** preload the FIFO with 0..15, hold `out_ready`=1 → `out_valid` rises 2 cycles after the first `fifo_rd_en`.
  - Words 0..15 arrive on consecutive cycles.
  - `out_last` is set on words 3, 7, 11, 15; `pkt_count`=4.
- **Backpressure:** 16 words loaded, `out_ready`=0 → exactly 2 reads are issued and `out_data`=0 is held.
  - Release `out_ready` → words 0..15 arrive in order, none lost or duplicated.
- **Simultaneous write/read:** concurrent FIFO writes of 100..131 with random `out_ready` → the stream equals 100..131.
  - `fifo_rd_en` is never high with `fifo_empty` high.
  - `occ` never exceeds 2.
- **Reset mid-packet:** after 2 words of a packet, pulse `rstn` low → `out_valid`=0 immediately.
  - The next packet's fourth word carries `out_last`; `pkt_count` restarts from 0.
- **PKT_LEN=1 build, 200 random words with random `out_ready`:**
  - every word has `out_last`=1;
  - `pkt_count`=200;
  - data matches a scoreboard queue.
